// File: rtl/icache_sa_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
// Instances may override the geometry; the helper functions derive the field layout from it.
package icache_pkg;

    typedef enum logic {IDLE, REFILL} state_t;

    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_OFF_BITS = 2;
    localparam int DEF_SET_BITS = 5;
    localparam int DEF_WAYS     = 2;

    localparam int LINE_WORDS = 1 << DEF_OFF_BITS;
    localparam int OFF_LSB    = 2;
    localparam int SET_LSB    = OFF_LSB + DEF_OFF_BITS;
    localparam int TAG_LSB    = SET_LSB + DEF_SET_BITS;
    localparam int TAG_W      = DEF_ADDR_W - TAG_LSB;

    function automatic int tag_width(input int addr_w, input int off_bits, input int set_bits);
        return addr_w - off_bits - set_bits - 2;
    endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Word-read handshake between the instruction cache and the memory controller.
// The cache holds a request until the controller acknowledges it.
interface icache_sa_if #(
    parameter int ADDR_W = icache_pkg::DEF_ADDR_W
);

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_data_i
    );

endinterface

// File: rtl/icache_sa_way.sv
// One cache way: valid bits, tags and line data with synchronous write and asynchronous read.
// A global flush clears every valid bit; inval clears a single set.
module icache_way #(
    parameter int TAG_W    = icache_pkg::TAG_W,
    parameter int SET_BITS = icache_pkg::DEF_SET_BITS,
    parameter int OFF_BITS = icache_pkg::DEF_OFF_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inval,
    input  logic                tag_wr,
    input  logic                word_wr,
    input  logic [SET_BITS-1:0] wr_set,
    input  logic [OFF_BITS-1:0] wr_off,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [31:0]         wr_data,
    input  logic [SET_BITS-1:0] rd_set,
    input  logic [OFF_BITS-1:0] rd_off,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = SETS << OFF_BITS;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [WORDS];

    // A flush landing on the final refill edge wins over the valid set of the new line.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (inval) begin
            valid[wr_set] <= 1'b0;
        end else if (tag_wr) begin
            valid[wr_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr) begin
            tags[wr_set] <= wr_tag;
        end
        if (word_wr) begin
            data[{wr_set, wr_off}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_set];
    assign rd_tag   = tags[rd_set];
    assign rd_data  = data[{rd_set, rd_off}];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, LRU victim choice,
// word-by-word line refill with forwarding of the word being returned, and fence.i flush.
module icache_sa
    import icache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFF_BITS = DEF_OFF_BITS,
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int WAYS     = DEF_WAYS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              hit_o,
    output logic [31:0]       inst_o,
    input  logic              flush_i,
    output logic              busy_o,
    icache_sa_if.master       mem
);

    localparam int SLSB = OFF_BITS + 2;
    localparam int TLSB = SLSB + SET_BITS;
    localparam int TAGW = tag_width(ADDR_W, OFF_BITS, SET_BITS);
    localparam int SETS = 1 << SET_BITS;

    state_t              state, state_next;
    logic [OFF_BITS-1:0] cnt;
    logic                victim, victim_next, flush_pend;
    logic [SETS-1:0]     lru;
    logic                start, ack_take, last, flush_all;
    logic                enabled, fwd, array_hit, hit_way;
    logic [31:0]         hit_data;

    logic [WAYS-1:0]     way_valid;
    logic [TAGW-1:0]     way_tag  [WAYS];
    logic [31:0]         way_data [WAYS];

    logic [SET_BITS-1:0] req_set, fill_set, wr_set;
    logic [OFF_BITS-1:0] req_off;
    logic [TAGW-1:0]     req_tag, fill_tag;
    logic                addr_lsb_unused;

    assign req_off  = req_addr_i[SLSB-1:2];
    assign req_set  = req_addr_i[TLSB-1:SLSB];
    assign req_tag  = req_addr_i[ADDR_W-1:TLSB];
    assign fill_set = mem.mem_addr_o[TLSB-1:SLSB];
    assign fill_tag = mem.mem_addr_o[ADDR_W-1:TLSB];
    assign wr_set   = (state == IDLE) ? req_set : fill_set;
    assign addr_lsb_unused = ^{req_addr_i[1:0], mem.mem_addr_o[1:0]};

    assign flush_all = !rst && rdy &&
                       ((state == IDLE && flush_i) || (last && (flush_pend || flush_i)));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .TAG_W    (TAGW),
            .SET_BITS (SET_BITS),
            .OFF_BITS (OFF_BITS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush_all),
            .inval    (start && victim_next == 1'(w)),
            .tag_wr   (last && victim == 1'(w)),
            .word_wr  (ack_take && victim == 1'(w)),
            .wr_set   (wr_set),
            .wr_off   (cnt),
            .wr_tag   (fill_tag),
            .wr_data  (mem.mem_data_i),
            .rd_set   (req_set),
            .rd_off   (req_off),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
    end

    // Tag compare across ways; the lowest matching way wins.
    always_comb begin
        array_hit = 1'b0;
        hit_way   = 1'b0;
        hit_data  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && way_tag[w] == req_tag) begin
                array_hit = 1'b1;
                hit_way   = 1'(w);
                hit_data  = way_data[w];
            end
        end
    end

    // First invalid way is preferred; otherwise the set's LRU bit names the victim.
    always_comb begin
        victim_next = 1'b0;
        if (WAYS > 1 && way_valid[0]) begin
            victim_next = way_valid[WAYS-1] ? lru[req_set] : 1'b1;
        end
    end

    assign enabled = !rst && rdy;
    assign fwd     = (state == REFILL) && mem.mem_ack_i &&
                     (req_addr_i[ADDR_W-1:2] == mem.mem_addr_o[ADDR_W-1:2]);
    assign hit_o   = enabled && (fwd || array_hit);
    assign inst_o  = !enabled ? 32'h0 : fwd ? mem.mem_data_i : array_hit ? hit_data : 32'h0;
    assign busy_o  = (state == REFILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        ack_take   = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (rdy && req_valid_i && !array_hit && !flush_i) begin
                    start      = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (rdy && mem.mem_req_o && mem.mem_ack_i) begin
                    ack_take = 1'b1;
                    if (cnt == '1) begin
                        last       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Refill bookkeeping and replacement state; everything holds while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req_o  <= 1'b0;
            mem.mem_addr_o <= '0;
            cnt            <= '0;
            victim         <= 1'b0;
            flush_pend     <= 1'b0;
            lru            <= '0;
        end else if (rdy) begin
            if (start) begin
                mem.mem_req_o  <= 1'b1;
                mem.mem_addr_o <= {req_addr_i[ADDR_W-1:SLSB], {SLSB{1'b0}}};
                cnt            <= '0;
                victim         <= victim_next;
            end
            if (ack_take && !last) begin
                cnt            <= cnt + OFF_BITS'(1);
                mem.mem_addr_o <= mem.mem_addr_o + ADDR_W'(4);
            end
            if (last) begin
                mem.mem_req_o <= 1'b0;
                cnt           <= '0;
                lru[fill_set] <= ~victim;
                flush_pend    <= 1'b0;
            end else if (state == REFILL && flush_i) begin
                flush_pend <= 1'b1;
            end
            if (state == IDLE && req_valid_i && array_hit) begin
                lru[req_set] <= ~hit_way;
            end
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: a memory responder with an address scoreboard,
// a lookup vector table and hand-written sequences for flush, reset and stall cases.
module tb_icache_sa;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, req_valid, flush;
    logic [16:0] req_addr;
    logic        hit;
    logic [31:0] inst;
    logic        busy;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] sb [$];

    typedef struct {
        logic [16:0] addr;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    icache_sa_if #(.ADDR_W(17)) mem_bus ();

    icache_sa #(
        .ADDR_W   (17),
        .OFF_BITS (2),
        .SET_BITS (5),
        .WAYS     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .hit_o       (hit),
        .inst_o      (inst),
        .flush_i     (flush),
        .busy_o      (busy),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] memWord(input logic [16:0] a);
        return {8'hC3, 7'h00, a} ^ 32'h00A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [16:0] addr, input logic fl);
        req_valid = valid;
        req_addr  = addr;
        flush     = fl;
    endtask

    task automatic lookup(input string name, input logic [16:0] addr, input logic exp_hit, input logic [31:0] exp_data);
        applyStimulus(1'b1, addr, 1'b0);
        #1;
        checkOutput({name, " hit"}, 32'(hit), 32'(exp_hit));
        checkOutput({name, " inst"}, inst, exp_data);
        applyStimulus(1'b0, addr, 1'b0);
    endtask

    task automatic startFill(input logic [16:0] addr);
        applyStimulus(1'b1, addr, 1'b0);
        #1;
        checkOutput("fill start miss", 32'(hit), 32'h0);
        for (int k = 0; k < 4; k++) sb.push_back({addr[16:4], 4'h0} + 17'(4 * k));
        tick();
        applyStimulus(1'b0, addr, 1'b0);
        #1;
        checkOutput("req one cycle after miss", 32'(mem_bus.mem_req_o), 32'h1);
        checkOutput("busy during refill", 32'(busy), 32'h1);
    endtask

    task automatic ackOne(input logic [31:0] data_xor);
        logic [16:0] ea;
        int guard = 0;
        while (mem_bus.mem_req_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("mem req before ack", 32'(mem_bus.mem_req_o), 32'h1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard empty: got request %h, expected none", mem_bus.mem_addr_o);
            ea = '0;
        end else begin
            ea = sb.pop_front();
        end
        checkOutput("mem addr", 32'(mem_bus.mem_addr_o), 32'(ea));
        mem_bus.mem_ack_i  = 1'b1;
        mem_bus.mem_data_i = memWord(ea) ^ data_xor;
        tick();
        mem_bus.mem_ack_i  = 1'b0;
        mem_bus.mem_data_i = '0;
    endtask

    task automatic fill(input logic [16:0] addr);
        startFill(addr);
        for (int k = 0; k < 4; k++) ackOne(32'h0);
        #1;
        checkOutput("busy after fill", 32'(busy), 32'h0);
    endtask

    initial begin
        vec_t        table_v [7];
        logic [16:0] ea;

        rst = 1'b1;
        rdy = 1'b1;
        mem_bus.mem_ack_i  = 1'b0;
        mem_bus.mem_data_i = '0;
        applyStimulus(1'b1, 17'h00040, 1'b0);
        tick();
        #1;
        checkOutput("reset hit", 32'(hit), 32'h0);
        checkOutput("reset inst", inst, 32'h0);
        tick();
        checkOutput("reset mem_req", 32'(mem_bus.mem_req_o), 32'h0);
        checkOutput("reset mem_addr", 32'(mem_bus.mem_addr_o), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 17'h0, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] cold miss with forwarding of 0x48");
        startFill(17'h00040);
        applyStimulus(1'b1, 17'h00048, 1'b0);
        for (int k = 0; k < 4; k++) begin
            ea = sb.pop_front();
            #1;
            checkOutput("fwd pre-ack hit", 32'(hit), 32'h0);
            checkOutput("fwd mem addr", 32'(mem_bus.mem_addr_o), 32'(ea));
            if (k == 1) begin
                tick();
                #1;
                checkOutput("addr stable without ack", 32'(mem_bus.mem_addr_o), 32'(ea));
            end
            mem_bus.mem_ack_i  = 1'b1;
            mem_bus.mem_data_i = memWord(ea);
            #1;
            checkOutput("fwd ack-cycle hit", 32'(hit), 32'(ea == 17'h00048));
            checkOutput("fwd ack-cycle inst", inst, (ea == 17'h00048) ? memWord(ea) : 32'h0);
            tick();
            mem_bus.mem_ack_i  = 1'b0;
            mem_bus.mem_data_i = '0;
        end
        #1;
        checkOutput("busy after fwd fill", 32'(busy), 32'h0);
        checkOutput("0x48 hit after fill", 32'(hit), 32'h1);
        checkOutput("0x48 inst after fill", inst, memWord(17'h00048));
        applyStimulus(1'b0, 17'h0, 1'b0);

        table_v[0] = '{17'h00040, 1'b1, memWord(17'h00040)};
        table_v[1] = '{17'h00044, 1'b1, memWord(17'h00044)};
        table_v[2] = '{17'h00048, 1'b1, memWord(17'h00048)};
        table_v[3] = '{17'h0004C, 1'b1, memWord(17'h0004C)};
        table_v[4] = '{17'h00050, 1'b0, 32'h0};
        table_v[5] = '{17'h00240, 1'b0, 32'h0};
        table_v[6] = '{17'h00000, 1'b0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            lookup($sformatf("table[%0d]", i), table_v[i].addr, table_v[i].exp_hit, table_v[i].exp_data);
        end
        tick();

        $display("[TB] LRU replacement");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lookup("0x40 gone after reset", 17'h00040, 1'b0, 32'h0);
        fill(17'h00000);
        fill(17'h01000);
        applyStimulus(1'b1, 17'h00000, 1'b0);
        #1;
        checkOutput("lru touch hit", 32'(hit), 32'h1);
        tick();
        applyStimulus(1'b0, 17'h0, 1'b0);
        fill(17'h02000);
        lookup("lru 0x0000 kept", 17'h00000, 1'b1, memWord(17'h00000));
        lookup("lru 0x2000 new", 17'h02004, 1'b1, memWord(17'h02004));
        lookup("lru 0x1000 evicted", 17'h01000, 1'b0, 32'h0);

        $display("[TB] flush during refill");
        startFill(17'h00040);
        ackOne(32'h0);
        flush = 1'b1;
        ackOne(32'h0);
        flush = 1'b0;
        #1;
        checkOutput("busy after flush pulse", 32'(busy), 32'h1);
        ackOne(32'h0);
        ackOne(32'h0);
        #1;
        checkOutput("busy after flushed fill", 32'(busy), 32'h0);
        lookup("flushed 0x40", 17'h00040, 1'b0, 32'h0);
        lookup("flushed 0x0000", 17'h00000, 1'b0, 32'h0);
        lookup("flushed 0x2000", 17'h02000, 1'b0, 32'h0);

        $display("[TB] reset during refill");
        tick();
        startFill(17'h00040);
        ackOne(32'h0);
        ackOne(32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid-refill reset mem_req", 32'(mem_bus.mem_req_o), 32'h0);
        checkOutput("mid-refill reset busy", 32'(busy), 32'h0);
        fill(17'h00040);
        lookup("refill after reset 0x44", 17'h00044, 1'b1, memWord(17'h00044));

        $display("[TB] rdy stall during refill");
        tick();
        startFill(17'h00080);
        ackOne(32'h0);
        rdy = 1'b0;
        mem_bus.mem_ack_i  = 1'b1;
        mem_bus.mem_data_i = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 17'h00040, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stall hit", 32'(hit), 32'h0);
            checkOutput("stall inst", inst, 32'h0);
            checkOutput("stall mem addr", 32'(mem_bus.mem_addr_o), 32'h00084);
            checkOutput("stall busy", 32'(busy), 32'h1);
            tick();
        end
        rdy = 1'b1;
        mem_bus.mem_ack_i  = 1'b0;
        mem_bus.mem_data_i = '0;
        applyStimulus(1'b0, 17'h0, 1'b0);
        ackOne(32'h0);
        ackOne(32'h0);
        ackOne(32'h0);
        #1;
        checkOutput("busy after stalled fill", 32'(busy), 32'h0);
        lookup("stalled line 0x84", 17'h00084, 1'b1, memWord(17'h00084));
        lookup("stalled line 0x80", 17'h00080, 1'b1, memWord(17'h00080));
        lookup("other line 0x40", 17'h00040, 1'b1, memWord(17'h00040));

        $display("[TB] flush while idle");
        applyStimulus(1'b1, 17'h000C0, 1'b1);
        tick();
        applyStimulus(1'b0, 17'h0, 1'b0);
        #1;
        checkOutput("idle flush suppresses refill", 32'(mem_bus.mem_req_o), 32'h0);
        checkOutput("idle flush busy", 32'(busy), 32'h0);
        lookup("idle flush 0x40", 17'h00040, 1'b0, 32'h0);
        lookup("idle flush 0x80", 17'h00080, 1'b0, 32'h0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
